// File: rtl/alu_pkg.sv
// Shared constants, state encoding and the single-cycle operation function
// for the ALU execute stage.
package alu_pkg;
  localparam int DATA_W = 16;
  localparam int ITER_N = 16;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_XOR = 3'b100;
  localparam logic [2:0] OP_SHL = 3'b101;
  localparam logic [2:0] OP_MUL = 3'b110;
  localparam logic [2:0] OP_DIV = 3'b111;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CALC = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  typedef struct packed {
    logic [2*DATA_W-1:0] data;
    logic                carry;
  } res_t;

  // Everything that finishes in one cycle, including the divide-by-zero shortcut.
  function automatic res_t single_op(input logic [2:0] op,
                                     input logic [DATA_W-1:0] a,
                                     input logic [DATA_W-1:0] b);
    res_t r;
    logic [DATA_W:0] s;
    r = '0;
    s = '0;
    case (op)
      OP_ADD: begin
        s = {1'b0, a} + {1'b0, b};
        r.data = {{(DATA_W-1){1'b0}}, s};
        r.carry = s[DATA_W];
      end
      OP_SUB: begin
        s = {1'b0, a} - {1'b0, b};
        r.data = {{(DATA_W-1){1'b0}}, s};
        r.carry = s[DATA_W];
      end
      OP_AND: r.data = {{DATA_W{1'b0}}, a & b};
      OP_OR:  r.data = {{DATA_W{1'b0}}, a | b};
      OP_XOR: r.data = {{DATA_W{1'b0}}, a ^ b};
      OP_SHL: r.data = {{DATA_W{1'b0}}, a << b[3:0]};
      OP_DIV: r.data = {a, {DATA_W{1'b1}}};
      default: r = '0;
    endcase
    return r;
  endfunction
endpackage

// File: rtl/alu_iter_muldiv.sv
// Iterative unsigned shift-add multiplier / restoring divider sharing one
// hi:lo register pair; one bit per cycle for ITER_N cycles.
module alu_iter_muldiv
  import alu_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic                mode,
  input  logic [DATA_W-1:0]   a,
  input  logic [DATA_W-1:0]   b,
  output logic                busy,
  output logic                done,
  output logic [2*DATA_W-1:0] result
);
  logic [4:0]        cnt;
  logic              md;
  logic [DATA_W-1:0] hi, lo, m;
  logic [DATA_W-1:0] hi_n, lo_n;
  logic [DATA_W:0]   sum, sh;

  // MUL: m=multiplicand, lo=multiplier. DIV: m=divisor, lo=dividend/quotient.
  always_comb begin
    sum = {1'b0, hi} + {1'b0, (lo[0] ? m : '0)};
    sh  = {hi, lo[DATA_W-1]};
    if (!md) begin
      hi_n = sum[DATA_W:1];
      lo_n = {sum[0], lo[DATA_W-1:1]};
    end else if (sh < {1'b0, m}) begin
      hi_n = sh[DATA_W-1:0];
      lo_n = {lo[DATA_W-2:0], 1'b0};
    end else begin
      hi_n = sh[DATA_W-1:0] - m;
      lo_n = {lo[DATA_W-2:0], 1'b1};
    end
  end

  assign done   = busy && (cnt == 5'(ITER_N-1));
  assign result = {hi_n, lo_n};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy <= 1'b0;
      cnt  <= '0;
      md   <= 1'b0;
      hi   <= '0;
      lo   <= '0;
      m    <= '0;
    end else if (start) begin
      busy <= 1'b1;
      cnt  <= '0;
      md   <= mode;
      hi   <= '0;
      lo   <= mode ? a : b;
      m    <= mode ? b : a;
    end else if (busy) begin
      hi  <= hi_n;
      lo  <= lo_n;
      cnt <= cnt + 5'd1;
      if (done) busy <= 1'b0;
    end
  end
endmodule

// File: rtl/alu_exec.sv
// ALU execute stage: IDLE/CALC/DONE control, single-cycle ops and result
// registers; MUL and non-zero DIV run through the iterative unit.
module alu_exec
  import alu_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic                Start,
  input  logic [2:0]          Op,
  input  logic [DATA_W-1:0]   ALU_in1,
  input  logic [DATA_W-1:0]   ALU_in2,
  output logic                Busy,
  output logic                Done,
  output logic [2*DATA_W-1:0] Wb_data,
  output logic                Zero,
  output logic                Carry,
  output logic                Div_err
);
  logic [1:0]          state;
  logic [2:0]          op_q;
  logic                accept, iterative, iter_done;
  logic [2*DATA_W-1:0] iter_res;
  res_t                sres;

  assign accept    = Start && (state != S_CALC);
  assign iterative = (Op == OP_MUL) || ((Op == OP_DIV) && (ALU_in2 != '0));
  assign sres      = single_op(Op, ALU_in1, ALU_in2);
  assign Done      = (state == S_DONE);

  alu_iter_muldiv u_iter (
    .clk    (clk),
    .rst    (rst),
    .start  (accept && iterative),
    .mode   (Op == OP_DIV),
    .a      (ALU_in1),
    .b      (ALU_in2),
    .busy   (Busy),
    .done   (iter_done),
    .result (iter_res)
  );

  // Div_err tracks only the most recent DIV, so other ops leave it alone.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= S_IDLE;
      op_q    <= OP_ADD;
      Wb_data <= '0;
      Zero    <= 1'b0;
      Carry   <= 1'b0;
      Div_err <= 1'b0;
    end else if (accept && !iterative) begin
      state   <= S_DONE;
      op_q    <= Op;
      Wb_data <= sres.data;
      Zero    <= (sres.data == '0);
      Carry   <= sres.carry;
      if (Op == OP_DIV) Div_err <= 1'b1;
    end else if (accept) begin
      state <= S_CALC;
      op_q  <= Op;
    end else if (state == S_CALC) begin
      if (iter_done) begin
        state   <= S_DONE;
        Wb_data <= iter_res;
        Zero    <= (iter_res == '0);
        Carry   <= 1'b0;
        if (op_q == OP_DIV) Div_err <= 1'b0;
      end
    end else if (state == S_DONE) begin
      state <= S_IDLE;
    end
  end
endmodule

// File: tb/tb_alu_exec.sv
// Directed bench for alu_exec: expected results queued at issue, popped at Done.
module tb_alu_exec;
  logic        clk = 1'b0, rst = 1'b1, Start = 1'b0;
  logic [2:0]  Op = '0;
  logic [15:0] ALU_in1 = '0, ALU_in2 = '0;
  logic        Busy, Done, Zero, Carry, Div_err;
  logic [31:0] Wb_data;

  typedef struct {
    logic [31:0] d;
    logic        z;
    logic        c;
    logic        e;
  } exp_t;

  exp_t sb[$];
  int   total = 0, bad = 0;

  alu_exec dut (
    .clk(clk), .rst(rst), .Start(Start), .Op(Op), .ALU_in1(ALU_in1), .ALU_in2(ALU_in2),
    .Busy(Busy), .Done(Done), .Wb_data(Wb_data), .Zero(Zero), .Carry(Carry), .Div_err(Div_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Drive one Start cycle; returns at #1 after the accepting edge (cycle 1).
  task automatic issue(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b,
                       input bit push, input logic [31:0] d, input logic c, input logic e);
    @(negedge clk);
    Start = 1'b1; Op = op; ALU_in1 = a; ALU_in2 = b;
    if (push) sb.push_back('{d, (d == 32'h0), c, e});
    @(posedge clk); #1;
    Start = 1'b0; Op = 3'($urandom); ALU_in1 = 16'($urandom); ALU_in2 = 16'($urandom);
  endtask

  task automatic expect_done(input string tag, input int lat, input int busy);
    int   n = 1;
    int   b = 0;
    exp_t x;
    while (!Done && n < 40) begin
      if (Busy) b++;
      @(posedge clk); #1;
      n++;
    end
    chk({tag, "_lat"}, n, lat);
    chk({tag, "_busy"}, b, busy);
    if (Done && sb.size() > 0) begin
      x = sb.pop_front();
      chk({tag, "_wb"}, Wb_data, x.d);
      chk({tag, "_zero"}, Zero, x.z);
      chk({tag, "_carry"}, Carry, x.c);
      chk({tag, "_diverr"}, Div_err, x.e);
    end else if (Done) begin
      chk({tag, "_sb"}, sb.size(), 1);
    end
  endtask

  initial begin
    int dn;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_flags", {Busy, Done, Zero, Carry, Div_err}, 0);
    chk("rst_wb", Wb_data, 0);
    rst = 1'b0;

    // single-cycle ops, issued back-to-back from DONE
    issue(3'b000, 16'hFFFF, 16'h0001, 1, 32'h0001_0000, 1, 0); expect_done("add_carry", 1, 0);
    issue(3'b001, 16'h0005, 16'h0005, 1, 32'h0000_0000, 0, 0); expect_done("sub_zero", 1, 0);
    issue(3'b001, 16'h0001, 16'h0002, 1, 32'h0001_FFFF, 1, 0); expect_done("sub_borrow", 1, 0);
    issue(3'b010, 16'hF0F0, 16'hFF00, 1, 32'h0000_F000, 0, 0); expect_done("and", 1, 0);
    issue(3'b011, 16'hF0F0, 16'hFF00, 1, 32'h0000_FFF0, 0, 0); expect_done("or", 1, 0);
    issue(3'b100, 16'hF0F0, 16'hFF00, 1, 32'h0000_0FF0, 0, 0); expect_done("xor", 1, 0);
    issue(3'b101, 16'h8001, 16'hFFF1, 1, 32'h0000_0002, 0, 0); expect_done("shl", 1, 0);
    @(posedge clk); #1;
    chk("done_pulse", Done, 0);
    chk("wb_hold", Wb_data, 32'h0000_0002);

    // iterative ops
    issue(3'b110, 16'hFFFF, 16'hFFFF, 1, 32'hFFFE_0001, 0, 0); expect_done("mul_max", 17, 16);
    issue(3'b110, 16'h1234, 16'h0010, 1, 32'h0001_2340, 0, 0); expect_done("mul", 17, 16);
    issue(3'b110, 16'h0003, 16'h0005, 1, 32'h0000_000F, 0, 0);
    repeat (4) @(posedge clk);
    #1;
    chk("busy_c5", Busy, 1);
    Start = 1'b1; Op = 3'b000; ALU_in1 = 16'd2; ALU_in2 = 16'd3;
    @(posedge clk); #1;
    Start = 1'b0;
    expect_done("mul_ign", 12, 11);
    dn = 0;
    repeat (3) begin @(posedge clk); #1; if (Done) dn++; end
    chk("ign_no_extra", dn, 0);

    issue(3'b111, 16'd100,  16'd7,    1, 32'h0002_000E, 0, 0); expect_done("div", 17, 16);
    issue(3'b111, 16'h1234, 16'h0000, 1, 32'h1234_FFFF, 0, 1); expect_done("div0", 1, 0);
    issue(3'b111, 16'hFFFF, 16'h0001, 1, 32'h0000_FFFF, 0, 0); expect_done("div1", 17, 16);
    issue(3'b111, 16'd5,    16'd10,   1, 32'h0005_0000, 0, 0); expect_done("div_small", 17, 16);

    // reset in the middle of a MUL
    issue(3'b110, 16'hFFFF, 16'hFFFF, 0, 32'h0, 0, 0);
    repeat (4) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("abort_flags", {Busy, Done, Zero, Carry, Div_err}, 0);
    chk("abort_wb", Wb_data, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    dn = 0;
    repeat (20) begin @(posedge clk); #1; if (Done || Busy) dn++; end
    chk("abort_no_done", dn, 0);
    issue(3'b000, 16'd2, 16'd3, 1, 32'h0000_0005, 0, 0); expect_done("add_after_rst", 1, 0);

    chk("sb_empty", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
